// File: rtl/four_phase_handshake_rx_pkg.sv
// Shared types and helpers for the four-phase handshake responder.
// Latency: none (package only).
// Backpressure: none (package only).
package four_phase_pkg;

    typedef enum logic {FP_IDLE, FP_ACK} four_phase_state_e;

    // Width of a counter that must hold the values 0..cycles inclusive.
    function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/four_phase_handshake_rx.sv
// Four-phase req/ack responder feeding a one-word valid/ready stream register.
// Latency: req_i high at edge n gives ack_o, valid_o and data_o after edge n; 2 clocks per word minimum.
// Backpressure: a full, non-draining buffer holds ack_o low so the initiator stalls.
// Optional request-timeout watchdog: define COMMON_CELLS_4PH_TIMEOUT_EN.
module four_phase_handshake_rx
    import four_phase_pkg::*;
#(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 ack_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 error_o
);

    // A zero timeout would fire before the initiator could ever respond.
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("TimeoutCycles must be >= 1");
    end

    four_phase_state_e    r_state;
    logic                 r_ack;
    logic                 r_valid;
    logic [DataWidth-1:0] r_data;

    logic w_buf_free;
    logic w_capture;

    // A word leaving this cycle frees the slot, so capture and drain can overlap.
    assign w_buf_free = !r_valid || ready_i;
    assign w_capture  = (r_state == FP_IDLE) && req_i && w_buf_free;

    // Handshake FSM plus the single-word stream buffer; all outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= FP_IDLE;
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                FP_IDLE: begin
                    if (w_capture) begin
                        r_state <= FP_ACK;
                        r_ack   <= 1'b1;
                    end
                end
                FP_ACK: begin
                    if (!req_i) begin
                        r_state <= FP_IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= FP_IDLE;
                    r_ack   <= 1'b0;
                end
            endcase

            if (w_capture) begin
                r_valid <= 1'b1;
                r_data  <= data_i;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign ack_o   = r_ack;
    assign valid_o = r_valid;
    assign data_o  = r_data;

`ifdef COMMON_CELLS_4PH_TIMEOUT_EN
    localparam int unsigned TimeoutCntWidth = timeout_cnt_width(TimeoutCycles);

    logic [TimeoutCntWidth-1:0] r_cnt;
    logic                       r_error;

    // Count cycles req_i stays high in ACK; error fires the edge the count reaches the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= '0;
            r_error <= 1'b0;
        end else if (w_capture) begin
            r_cnt <= '0;
        end else if ((r_state == FP_ACK) && req_i) begin
            if (r_cnt != TimeoutCntWidth'(TimeoutCycles)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt >= TimeoutCntWidth'(TimeoutCycles - 1)) begin
                r_error <= 1'b1;
            end
        end
    end

    assign error_o = r_error;
`else
    assign error_o = 1'b0;
`endif

`ifndef SYNTHESIS
    // A stalled stream word must not change under the consumer.
    a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_valid && !ready_i) |=> (r_valid && $stable(r_data)));
`endif

endmodule

// File: tb/tb_four_phase_handshake_rx.sv
// Directed bench for four_phase_handshake_rx: vector table plus hand-written sequences.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: exercised through ready_i held low in the vector table.
module tb_four_phase_handshake_rx;

    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk_i   = 1'b0;
    logic          rst_ni  = 1'b0;
    logic          req_i   = 1'b0;
    logic [DW-1:0] data_i  = '0;
    logic          ready_i = 1'b0;
    logic          ack_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          error_o;

    int n_tests = 0;
    int n_fail  = 0;

    four_phase_handshake_rx #(
        .DataWidth     (DW),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .data_i  (data_i),
        .ack_o   (ack_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .error_o (error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          req;
        logic          rdy;
        logic [DW-1:0] dat;
        logic          exp_ack;
        logic          exp_vld;
        logic [DW-1:0] exp_dat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Hard stop if anything stalls the sequence.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        int   got;
        int   cyc;
        int   nxt;

        // Single transfer, then backpressure with overlapping drain/capture.
        vecs[0]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 1'b0, 32'hAAAA_0001, 1'b1, 1'b1, 32'hAAAA_0001};
        vecs[5]  = '{1'b0, 1'b0, 32'hAAAA_0001, 1'b0, 1'b1, 32'hAAAA_0001};
        vecs[6]  = '{1'b1, 1'b0, 32'hBBBB_0002, 1'b0, 1'b1, 32'hAAAA_0001};
        vecs[7]  = '{1'b1, 1'b0, 32'hBBBB_0002, 1'b0, 1'b1, 32'hAAAA_0001};
        vecs[8]  = '{1'b1, 1'b1, 32'hBBBB_0002, 1'b1, 1'b1, 32'hBBBB_0002};
        vecs[9]  = '{1'b0, 1'b0, 32'hBBBB_0002, 1'b0, 1'b1, 32'hBBBB_0002};
        vecs[10] = '{1'b0, 1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 32'hBBBB_0002};

        // Reset held, then released with req_i low.
        step();
        step();
        rst_ni = 1'b1;
        step();
        check("reset ack_o",   32'(ack_o),   32'd0);
        check("reset valid_o", 32'(valid_o), 32'd0);
        check("reset data_o",  data_o,       32'd0);
        check("reset error_o", 32'(error_o), 32'd0);

        foreach (vecs[i]) begin
            req_i   = vecs[i].req;
            ready_i = vecs[i].rdy;
            data_i  = vecs[i].dat;
            step();
            check($sformatf("vec%0d ack_o", i),   32'(ack_o),   32'(vecs[i].exp_ack));
            check($sformatf("vec%0d valid_o", i), 32'(valid_o), 32'(vecs[i].exp_vld));
            check($sformatf("vec%0d data_o", i),  data_o,       vecs[i].exp_dat);
            check($sformatf("vec%0d error_o", i), 32'(error_o), 32'd0);
        end

        // Back-to-back: initiator drops req on ack and re-raises as soon as ack falls.
        ready_i = 1'b1;
        req_i   = 1'b1;
        data_i  = 32'd0;
        nxt     = 1;
        got     = 0;
        cyc     = 0;
        while (got < 10 && cyc < 60) begin
            step();
            cyc++;
            if (valid_o) begin
                check($sformatf("b2b word%0d data", got), data_o, 32'(got));
                check($sformatf("b2b word%0d cycle", got), 32'(cyc), 32'(2 * got + 1));
                got++;
            end
            if (ack_o) begin
                req_i = 1'b0;
            end else if (!req_i && nxt < 10) begin
                req_i  = 1'b1;
                data_i = 32'(nxt);
                nxt++;
            end
        end
        check("b2b word count", 32'(got), 32'd10);
        req_i = 1'b0;
        step();
        check("b2b final ack_o", 32'(ack_o), 32'd0);

        // Hold req high after ack to exercise the timeout watchdog.
        req_i  = 1'b1;
        data_i = 32'h5555_5555;
        step();
        check("tmo ack rose", 32'(ack_o), 32'd1);
        check("tmo error at ack", 32'(error_o), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
`ifdef COMMON_CELLS_4PH_TIMEOUT_EN
            check($sformatf("tmo error +%0d", k), 32'(error_o), (k >= int'(TO)) ? 32'd1 : 32'd0);
`else
            check($sformatf("tmo error +%0d", k), 32'(error_o), 32'd0);
`endif
            check($sformatf("tmo ack held +%0d", k), 32'(ack_o), 32'd1);
        end
        req_i = 1'b0;
        step();
        check("tmo ack dropped", 32'(ack_o), 32'd0);
`ifdef COMMON_CELLS_4PH_TIMEOUT_EN
        check("tmo error sticky", 32'(error_o), 32'd1);
`else
        check("tmo error sticky", 32'(error_o), 32'd0);
`endif

        // Asynchronous reset while in ACK with a buffered word.
        ready_i = 1'b0;
        req_i   = 1'b1;
        data_i  = 32'h0000_0077;
        step();
        check("rst pre ack_o",   32'(ack_o),   32'd1);
        check("rst pre valid_o", 32'(valid_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async rst ack_o",   32'(ack_o),   32'd0);
        check("async rst valid_o", 32'(valid_o), 32'd0);
        check("async rst data_o",  data_o,       32'd0);
        check("async rst error_o", 32'(error_o), 32'd0);
        data_i = 32'h0000_0088;
        step();
        step();
        rst_ni = 1'b1;
        step();
        check("post rst ack_o",   32'(ack_o),   32'd1);
        check("post rst valid_o", 32'(valid_o), 32'd1);
        check("post rst data_o",  data_o,       32'h0000_0088);
        check("post rst error_o", 32'(error_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
